// File: rtl/mult_rr_scheduler_if.sv
// Request, response and engine-side signal bundle for mult_rr_scheduler.
// master = clients plus engine (drive operands, eng_done/eng_c); slave = the scheduler.
interface mult_rr_scheduler_if #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned SIZEA = 571,
    parameter int unsigned SIZEB = 571
);
    localparam int unsigned CW = SIZEA + SIZEB;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*SIZEA-1:0] req_a;
    logic [NREQ*SIZEB-1:0] req_b;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [CW-1:0]         rsp_c;
    logic                  rsp_err;
    logic [SIZEA-1:0]      eng_a;
    logic [SIZEB-1:0]      eng_b;
    logic                  eng_start;
    logic                  eng_clr;
    logic                  eng_done;
    logic [CW-1:0]         eng_c;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, eng_done, eng_c,
        input  req_ready, rsp_valid, rsp_c, rsp_err, eng_a, eng_b, eng_start, eng_clr, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, eng_done, eng_c,
        output req_ready, rsp_valid, rsp_c, rsp_err, eng_a, eng_b, eng_start, eng_clr, busy
    );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one digit-serial multiplier engine among NREQ requesters.
// Optional WAIT-phase watchdog is built in when MULT_SCHED_WDOG_EN is defined.
module mult_rr_scheduler #(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned SIZEA       = 571,
    parameter int unsigned SIZEB       = 571,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    mult_rr_scheduler_if.slave bus
);
    localparam int unsigned CW    = SIZEA + SIZEB;
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] cur;
    logic [NREQ-1:0]  rsp_valid_q;
    logic [CW-1:0]    rsp_c_q;
    logic [SIZEA-1:0] eng_a_q;
    logic [SIZEB-1:0] eng_b_q;
    logic             eng_start_q;
    logic             eng_clr_q;
    logic             busy_q;

    logic             gnt_any;
    logic [PTR_W-1:0] gnt_idx;
    logic [SUM_W-1:0] scan;
    logic [NREQ-1:0]  gnt_oh;
    logic [NREQ-1:0]  cur_oh;
    logic [SIZEA-1:0] sel_a;
    logic [SIZEB-1:0] sel_b;
    logic             rsp_hs;

`ifdef MULT_SCHED_WDOG_EN
    localparam int unsigned        WDOG_W    = 13;
    localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              rsp_err_q;
    logic              wdog_hit;

    assign wdog_hit    = (wdog_cnt == WDOG_LAST);
    assign bus.rsp_err = rsp_err_q;
`else
    logic unused_wdog_cfg;

    assign unused_wdog_cfg = ^WDOG_CYCLES;
    assign bus.rsp_err     = 1'b0;
`endif

    // Search ptr+1, ptr+2, ... modulo NREQ; first pending requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan = {1'b0, ptr} + SUM_W'(k);
            if (scan >= SUM_W'(NREQ)) begin
                scan = scan - SUM_W'(NREQ);
            end
            if (!gnt_any && bus.req_valid[scan[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[PTR_W-1:0];
            end
        end
    end

    // One-hot decodes of the grant and the job in flight, plus operand select.
    always_comb begin
        gnt_oh = '0;
        cur_oh = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                gnt_oh[i] = 1'b1;
                sel_a     = bus.req_a[i*SIZEA +: SIZEA];
                sel_b     = bus.req_b[i*SIZEB +: SIZEB];
            end
            if (cur == PTR_W'(i)) begin
                cur_oh[i] = 1'b1;
            end
        end
    end

    // Only the flagged requester's ready bit can complete a response.
    assign rsp_hs = |(bus.rsp_ready & rsp_valid_q);

    // Accept strobe is the only combinational output: valid-to-ready in IDLE.
    assign bus.req_ready = (state == IDLE && gnt_any && !rst) ? gnt_oh : '0;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.eng_a     = eng_a_q;
    assign bus.eng_b     = eng_b_q;
    assign bus.eng_start = eng_start_q;
    assign bus.eng_clr   = eng_clr_q;
    assign bus.busy      = busy_q;

    // Job sequencing with registered engine controls and response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= PTR_W'(NREQ - 1);
            cur         <= '0;
            rsp_valid_q <= '0;
            rsp_c_q     <= '0;
            eng_a_q     <= '0;
            eng_b_q     <= '0;
            eng_start_q <= 1'b0;
            eng_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MULT_SCHED_WDOG_EN
            wdog_cnt    <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            eng_start_q <= 1'b0;
            eng_clr_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        eng_a_q     <= sel_a;
                        eng_b_q     <= sel_b;
                        cur         <= gnt_idx;
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef MULT_SCHED_WDOG_EN
                    wdog_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.eng_done) begin
                        rsp_c_q     <= bus.eng_c;
                        rsp_valid_q <= cur_oh;
`ifdef MULT_SCHED_WDOG_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state       <= RESP;
                    end
`ifdef MULT_SCHED_WDOG_EN
                    // Engine hung: reset it and return an error response instead.
                    else if (wdog_hit) begin
                        eng_clr_q   <= 1'b1;
                        rsp_c_q     <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= cur_oh;
                        state       <= RESP;
                    end else begin
                        wdog_cnt <= wdog_cnt + WDOG_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= '0;
                        eng_clr_q   <= 1'b1;
                        ptr         <= cur;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed self-checking bench for mult_rr_scheduler with a fixed-latency carry-less engine model.
// Watchdog expectations follow MULT_SCHED_WDOG_EN.
module tb_mult_rr_scheduler;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned SIZEA = 571;
    localparam int unsigned SIZEB = 571;
    localparam int unsigned CW    = SIZEA + SIZEB;
    localparam int unsigned WDOG  = 16;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    mult_rr_scheduler_if #(.NREQ(NREQ), .SIZEA(SIZEA), .SIZEB(SIZEB)) bus ();

    mult_rr_scheduler #(
        .NREQ(NREQ), .SIZEA(SIZEA), .SIZEB(SIZEB), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (low 128 bits, %0d bits differ)",
                     tag, got[127:0], exp[127:0], $countones(got ^ exp));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input int idx, input logic [SIZEA-1:0] a, input logic [SIZEB-1:0] b);
        if (idx == 0) begin
            bus.req_a[0 +: SIZEA] = a;
            bus.req_b[0 +: SIZEB] = b;
        end else begin
            bus.req_a[SIZEA +: SIZEA] = a;
            bus.req_b[SIZEB +: SIZEB] = b;
        end
    endtask

    function automatic logic [CW-1:0] clmul(input logic [SIZEA-1:0] a, input logic [SIZEB-1:0] b);
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(SIZEB); i++) begin
            if (b[i]) acc = acc ^ (CW'(a) << i);
        end
        return acc;
    endfunction

    // Engine model: one-cycle done pulse carrying the carry-less product of the driven operands.
    task automatic engine_done();
        bus.eng_done = 1'b1;
        bus.eng_c    = clmul(bus.eng_a, bus.eng_b);
        tick();
        bus.eng_done = 1'b0;
    endtask

    logic [SIZEA-1:0] ones;
    logic [CW-1:0]    exp_sq;
    logic [NREQ-1:0]  exp_g;
    logic [CW-1:0]    exp_c;
    int               n;

    initial begin
        n_vec = 0;
        n_bad = 0;
        ones  = '1;
        // (2^571-1)^2 carry-less: bit k set iff k is even (odd count of i+j=k pairs).
        exp_sq = '0;
        for (int k = 0; k < int'(CW); k++) exp_sq[k] = (k % 2 == 0);

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        bus.eng_done  = 1'b0;
        bus.eng_c     = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_busy",      CW'(bus.busy),      '0);
        check("rst_rsp_valid", CW'(bus.rsp_valid), '0);
        check("rst_rsp_c",     bus.rsp_c,          '0);
        check("rst_rsp_err",   CW'(bus.rsp_err),   '0);
        check("rst_eng_a",     CW'(bus.eng_a),     '0);
        check("rst_eng_start", CW'(bus.eng_start), '0);
        check("rst_eng_clr",   CW'(bus.eng_clr),   '0);
        check("rst_req_ready", CW'(bus.req_ready), '0);

        // T1: single request from requester 0, 10-cycle engine
        set_op(0, SIZEA'(3), SIZEB'(5));
        bus.req_valid = 2'b01;
        #1;
        check("t1_req_ready", CW'(bus.req_ready), CW'(2'b01));
        tick();
        bus.req_valid = '0;
        #1;
        check("t1_eng_start",   CW'(bus.eng_start), CW'(1'b1));
        check("t1_eng_a",       CW'(bus.eng_a),     CW'(3));
        check("t1_eng_b",       CW'(bus.eng_b),     CW'(5));
        check("t1_busy",        CW'(bus.busy),      CW'(1'b1));
        check("t1_ready_issue", CW'(bus.req_ready), '0);
        tick();
        check("t1_start_pulse", CW'(bus.eng_start), '0);
        bus.req_valid = 2'b10;
        repeat (3) tick();
        check("t1_ready_wait", CW'(bus.req_ready), '0);
        bus.req_valid = '0;
        repeat (6) tick();
        engine_done();
        check("t1_rsp_valid", CW'(bus.rsp_valid), CW'(2'b01));
        check("t1_rsp_c",     bus.rsp_c,          CW'(15));
        check("t1_rsp_err",   CW'(bus.rsp_err),   '0);
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = '0;
        check("t1_eng_clr",     CW'(bus.eng_clr),   CW'(1'b1));
        check("t1_rsp_dropped", CW'(bus.rsp_valid), '0);
        check("t1_busy_idle",   CW'(bus.busy),      '0);
        tick();
        check("t1_clr_pulse",   CW'(bus.eng_clr),   '0);
        check("t1_stale_valid", CW'(bus.busy),      '0);

        // T2: both requesting from reset, rsp_ready held high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(0, SIZEA'(6), SIZEB'(3));
        set_op(1, SIZEA'(7), SIZEB'(7));
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        #1;
        for (int j = 0; j < 4; j++) begin
            exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
            exp_c = (j % 2 == 0) ? CW'(10) : CW'(21);
            check("t2_grant", CW'(bus.req_ready), CW'(exp_g));
            tick();
            check("t2_eng_start", CW'(bus.eng_start), CW'(1'b1));
            tick();
            check("t2_ready_wait", CW'(bus.req_ready), '0);
            tick();
            engine_done();
            check("t2_rsp_valid", CW'(bus.rsp_valid), CW'(exp_g));
            check("t2_rsp_c",     bus.rsp_c,          exp_c);
            tick();
            check("t2_eng_clr",   CW'(bus.eng_clr),   CW'(1'b1));
            check("t2_rsp_done",  CW'(bus.rsp_valid), '0);
        end
        bus.req_valid = '0;
        bus.rsp_ready = '0;

        // T3: 20 cycles of backpressure on requester 0's result
        set_op(0, SIZEA'(9), SIZEB'(3));
        bus.req_valid = 2'b01;
        #1;
        check("t3_req_ready", CW'(bus.req_ready), CW'(2'b01));
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        engine_done();
        check("t3_rsp_valid", CW'(bus.rsp_valid), CW'(2'b01));
        check("t3_rsp_c",     bus.rsp_c,          CW'(27));
        bus.req_valid = 2'b10;
        bus.rsp_ready = 2'b10;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bus.eng_done = 1'b1;
                bus.eng_c    = '1;
            end else begin
                bus.eng_done = 1'b0;
            end
            tick();
            check("t3_hold_c",     bus.rsp_c,          CW'(27));
            check("t3_hold_valid", CW'(bus.rsp_valid), CW'(2'b01));
            check("t3_hold_ready", CW'(bus.req_ready), '0);
            check("t3_hold_busy",  CW'(bus.busy),      CW'(1'b1));
        end
        bus.eng_done  = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = '0;
        check("t3_rsp_done", CW'(bus.rsp_valid), '0);
        check("t3_eng_clr",  CW'(bus.eng_clr),   CW'(1'b1));

        // T4: reset during WAIT abandons requester 1's job
        set_op(1, SIZEA'(5), SIZEB'(5));
        bus.req_valid = 2'b10;
        #1;
        check("t4_req_ready", CW'(bus.req_ready), CW'(2'b10));
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        bus.eng_done = 1'b1;
        bus.eng_c    = '1;
        #1;
        check("t4_busy",      CW'(bus.busy),      '0);
        check("t4_rsp_valid", CW'(bus.rsp_valid), '0);
        check("t4_rsp_c",     bus.rsp_c,          '0);
        check("t4_eng_a",     CW'(bus.eng_a),     '0);
        check("t4_eng_b",     CW'(bus.eng_b),     '0);
        check("t4_eng_start", CW'(bus.eng_start), '0);
        check("t4_eng_clr",   CW'(bus.eng_clr),   '0);
        check("t4_req_ready", CW'(bus.req_ready), '0);
        tick();
        bus.eng_done = 1'b0;
        check("t4_done_ignored", CW'(bus.busy),      '0);
        check("t4_no_response",  CW'(bus.rsp_valid), '0);

        // T5: full-width operands; grant after reset must go to requester 0
        set_op(0, ones, ones);
        set_op(1, SIZEA'(1), SIZEB'(1));
        bus.req_valid = 2'b11;
        #1;
        check("t4_next_grant", CW'(bus.req_ready), CW'(2'b01));
        tick();
        bus.req_valid = '0;
        check("t5_eng_a", CW'(bus.eng_a), CW'(ones));
        check("t5_eng_b", CW'(bus.eng_b), CW'(ones));
        tick();
        tick();
        engine_done();
        check("t5_rsp_valid", CW'(bus.rsp_valid), CW'(2'b01));
        check("t5_rsp_c",     bus.rsp_c,          exp_sq);
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = '0;
        check("t5_eng_clr", CW'(bus.eng_clr), CW'(1'b1));

        // T6: engine never finishes requester 1's job
        bus.req_valid = 2'b10;
        #1;
        check("t6_req_ready", CW'(bus.req_ready), CW'(2'b10));
        tick();
        bus.req_valid = '0;
        check("t6_eng_start", CW'(bus.eng_start), CW'(1'b1));
`ifdef MULT_SCHED_WDOG_EN
        n = 0;
        while (n < 60 && bus.rsp_valid == '0) begin
            tick();
            n++;
        end
        check("t6_wdog_latency", CW'(n),            CW'(WDOG + 1));
        check("t6_rsp_valid",    CW'(bus.rsp_valid), CW'(2'b10));
        check("t6_rsp_err",      CW'(bus.rsp_err),   CW'(1'b1));
        check("t6_rsp_c",        bus.rsp_c,          '0);
        check("t6_eng_clr",      CW'(bus.eng_clr),   CW'(1'b1));
        bus.rsp_ready = 2'b10;
        tick();
        bus.rsp_ready = '0;
        check("t6_rsp_done", CW'(bus.rsp_valid), '0);
        check("t6_idle",     CW'(bus.busy),      '0);
`else
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.rsp_valid != '0) n++;
        end
        check("t6_no_rsp",  CW'(n),           '0);
        check("t6_busy",    CW'(bus.busy),    CW'(1'b1));
        check("t6_rsp_err", CW'(bus.rsp_err), '0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
